// File: rtl/data_bus_arbiter_if.sv
// Bundle of the two requester ports and the shared slave port of data_bus_arbiter.
// master = arbiter side; slave = the environment (requesters and shared target).
interface data_bus_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  m0_req,    m1_req;
    logic                  m0_wren,   m1_wren;
    logic [ADDR_WIDTH-1:0] m0_addr,   m1_addr;
    logic [DATA_WIDTH-1:0] m0_wrdata, m1_wrdata;
    logic                  m0_gnt,    m1_gnt;
    logic                  m0_done,   m1_done;
    logic                  m0_err,    m1_err;
    logic [DATA_WIDTH-1:0] m0_rddata, m1_rddata;
    logic                  s_req;
    logic                  s_wren;
    logic [ADDR_WIDTH-1:0] s_addr;
    logic [DATA_WIDTH-1:0] s_wrdata;
    logic                  s_ack;
    logic [DATA_WIDTH-1:0] s_rddata;

    modport master (
        input  m0_req, m1_req, m0_wren, m1_wren, m0_addr, m1_addr, m0_wrdata, m1_wrdata,
        input  s_ack, s_rddata,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m0_rddata, m1_rddata,
        output s_req, s_wren, s_addr, s_wrdata
    );

    modport slave (
        output m0_req, m1_req, m0_wren, m1_wren, m0_addr, m1_addr, m0_wrdata, m1_wrdata,
        output s_ack, s_rddata,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err, m0_rddata, m1_rddata,
        input  s_req, s_wren, s_addr, s_wrdata
    );
endinterface

// File: rtl/data_bus_arbiter.sv
// Two-requester round-robin arbiter onto a single shared slave port, with an optional
// BUSY timeout that aborts a transaction the slave never acknowledges.
module data_bus_arbiter #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input logic               clk,
    input logic               rst,
    data_bus_arbiter_if.master bus
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax =
        (TIMEOUT_CYCLES > 0) ? CntW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_q, last_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            done_q, done_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rd0_q, rd0_d, rd1_q, rd1_d;
    logic [1:0]            gnt;
    logic                  win;
    logic                  fin;
    logic                  fin_err;
    logic [DATA_WIDTH-1:0] fin_data;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        wren_d   = wren_q;
        addr_d   = addr_q;
        wrdata_d = wrdata_q;
        cnt_d    = cnt_q;
        done_d   = '0;
        err_d    = '0;
        rd0_d    = rd0_q;
        rd1_d    = rd1_q;
        gnt      = '0;
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;
        // m1 wins when alone, or on a tie when m0 had the previous grant
        win      = bus.m1_req & (~bus.m0_req | ~last_q);

        unique case (state_q)
            StIdle: begin
                if (bus.m0_req | bus.m1_req) begin
                    gnt[win] = 1'b1;
                    owner_d  = win;
                    last_d   = win;
                    wren_d   = win ? bus.m1_wren   : bus.m0_wren;
                    addr_d   = win ? bus.m1_addr   : bus.m0_addr;
                    wrdata_d = win ? bus.m1_wrdata : bus.m0_wrdata;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                // An ack on the limit cycle takes priority over the timeout
                if (bus.s_ack) begin
                    fin      = 1'b1;
                    fin_data = wren_q ? '0 : bus.s_rddata;
                end else if (TIMEOUT_CYCLES != 0 && cnt_q == CntMax) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (fin) begin
                    state_d         = StIdle;
                    done_d[owner_q] = 1'b1;
                    err_d[owner_q]  = fin_err;
                    if (owner_q) rd1_d = fin_data;
                    else         rd0_d = fin_data;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wren_q   <= 1'b0;
            addr_q   <= '0;
            wrdata_q <= '0;
            cnt_q    <= '0;
            done_q   <= '0;
            err_q    <= '0;
            rd0_q    <= '0;
            rd1_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            wren_q   <= wren_d;
            addr_q   <= addr_d;
            wrdata_q <= wrdata_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd1_d;
        end
    end

    // Grants are combinational, so mask them while reset is held
    assign bus.m0_gnt    = gnt[0] & rst;
    assign bus.m1_gnt    = gnt[1] & rst;
    assign bus.m0_done   = done_q[0];
    assign bus.m1_done   = done_q[1];
    assign bus.m0_err    = err_q[0];
    assign bus.m1_err    = err_q[1];
    assign bus.m0_rddata = rd0_q;
    assign bus.m1_rddata = rd1_q;
    assign bus.s_req     = (state_q == StBusy);
    assign bus.s_wren    = wren_q;
    assign bus.s_addr    = addr_q;
    assign bus.s_wrdata  = wrdata_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Scoreboard bench for data_bus_arbiter: expected completions are queued at stimulus time
// and popped by a monitor when a done pulse appears.
module tb_data_bus_arbiter;
    localparam int TO = 16;

    typedef struct {
        logic        who;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   nt_done_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    data_bus_arbiter_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_nt ();

    data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    data_bus_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(0)) dut_nt (
        .clk(clk),
        .rst(rst),
        .bus(bus_nt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst) begin
            if (bus.m0_done | bus.m1_done) begin
                exp_t e;
                done_cnt++;
                check_eq("done_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check_eq("done_who", bus.m1_done, e.who);
                    check_eq("done_single", bus.m0_done & bus.m1_done, 0);
                    check_eq("done_err", e.who ? bus.m1_err : bus.m0_err, e.err);
                    check_eq("done_rddata", e.who ? bus.m1_rddata : bus.m0_rddata, e.data);
                end
            end
            if (bus_nt.m0_done | bus_nt.m1_done) nt_done_cnt++;
        end
    end

    task automatic busy_phase(input logic [31:0] addr, input logic [31:0] wd, input logic wr,
                              input int ack_at, input logic [31:0] rd, input int exp_busy,
                              input string tag);
        int   busy = 0;
        logic bad = 1'b0;
        logic gbad = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            bus.s_ack    = (c == ack_at);
            bus.s_rddata = rd;
            @(negedge clk);
            if (!bus.s_req) break;
            busy++;
            if (bus.s_addr !== addr || bus.s_wrdata !== wd || bus.s_wren !== wr) bad = 1'b1;
            if (bus.m0_gnt | bus.m1_gnt) gbad = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.s_ack = 1'b0;
        #1;
        check_eq({tag, "_busy_cycles"}, busy, exp_busy);
        check_eq({tag, "_s_stable"}, bad, 0);
        check_eq({tag, "_no_gnt_busy"}, gbad, 0);
        check_eq({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    task automatic do_txn(input logic who, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] rd,
                          input int exp_busy, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (who) begin
            bus.m1_req = 1'b1; bus.m1_wren = wr; bus.m1_addr = addr; bus.m1_wrdata = wd;
        end else begin
            bus.m0_req = 1'b1; bus.m0_wren = wr; bus.m0_addr = addr; bus.m0_wrdata = wd;
        end
        e.who  = who;
        e.err  = (ack_at == 0 || ack_at > TO);
        e.data = (e.err || wr) ? 32'h0 : rd;
        sb.push_back(e);
        @(negedge clk);
        check_eq({tag, "_gnt0"}, bus.m0_gnt, !who);
        check_eq({tag, "_gnt1"}, bus.m1_gnt, who);
        @(posedge clk);
        #1;
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
        busy_phase(addr, wd, wr, ack_at, rd, exp_busy, tag);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        int   n;
        int   dc;
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_wren = 0; bus.m1_wren = 0;
        bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wrdata = 0; bus.m1_wrdata = 0;
        bus.s_ack = 0; bus.s_rddata = 0;
        bus_nt.m0_req = 0; bus_nt.m1_req = 0; bus_nt.m0_wren = 0; bus_nt.m1_wren = 0;
        bus_nt.m0_addr = 0; bus_nt.m1_addr = 0; bus_nt.m0_wrdata = 0; bus_nt.m1_wrdata = 0;
        bus_nt.s_ack = 0; bus_nt.s_rddata = 0;

        // Reset state
        @(negedge clk);
        check_eq("rst_s_req", bus.s_req, 0);
        check_eq("rst_s_wren", bus.s_wren, 0);
        check_eq("rst_s_addr", bus.s_addr, 0);
        check_eq("rst_s_wrdata", bus.s_wrdata, 0);
        check_eq("rst_gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
        check_eq("rst_done", {bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err}, 0);
        check_eq("rst_rddata", {bus.m0_rddata, bus.m1_rddata}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Round robin with both requesting and an immediate ack
        @(posedge clk);
        #1;
        bus.m0_req = 1; bus.m1_req = 1; bus.m0_addr = 32'h10; bus.m1_addr = 32'h20;
        bus.s_ack = 1; bus.s_rddata = 32'h5A5A_0001;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc % 2 == 0) begin
                e.who = (cyc % 4 == 2); e.err = 0; e.data = 32'h5A5A_0001;
                sb.push_back(e);
            end
            @(negedge clk);
            check_eq("rr_gnt0", bus.m0_gnt, (cyc % 4 == 0));
            check_eq("rr_gnt1", bus.m1_gnt, (cyc % 4 == 2));
            @(posedge clk);
            #1;
            if (cyc == 6) begin
                bus.m0_req = 0; bus.m1_req = 0;
            end
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        bus.s_ack = 0;
        check_eq("rr_sb_drained", sb.size(), 0);

        // m0 read, ack on second BUSY cycle
        do_txn(0, 0, 32'h100, 32'h0, 2, 32'hCAFE_F00D, 2, "rd_m0");
        // m1 write that never gets an ack
        do_txn(1, 1, 32'h200, 32'h1234_5678, 0, 32'hFFFF_FFFF, TO, "tmo_m1");
        // Ack exactly on the limit cycle
        do_txn(0, 0, 32'h300, 32'h0, TO, 32'hDEAD_BEEF, TO, "ack_lim");
        // Write ack returns zero read data
        do_txn(1, 1, 32'h400, 32'hAAAA_5555, 1, 32'h7777_7777, 1, "wr_m1");

        // Ack while idle produces nothing
        dc = done_cnt;
        @(posedge clk);
        #1;
        bus.s_ack = 1; bus.s_rddata = 32'h1111_1111;
        repeat (3) @(posedge clk);
        #1;
        bus.s_ack = 0;
        @(negedge clk);
        check_eq("idle_ack_no_done", done_cnt - dc, 0);
        check_eq("idle_ack_no_sreq", bus.s_req, 0);

        // m0 request dropped right after grant still completes
        do_txn(0, 0, 32'h440, 32'h0, 3, 32'h1357_9BDF, 3, "drop_m0");

        // Reset during the second BUSY cycle
        @(posedge clk);
        #1;
        bus.m0_req = 1; bus.m0_wren = 0; bus.m0_addr = 32'h500; bus.m0_wrdata = 0;
        @(negedge clk);
        check_eq("rstmid_gnt0", bus.m0_gnt, 1);
        @(posedge clk);
        #1;
        bus.m0_req = 0;
        @(posedge clk);
        #1;
        check_eq("rstmid_busy", bus.s_req, 1);
        dc = done_cnt;
        bus.m0_req = 1; bus.m1_req = 1;
        #2;
        rst = 1'b0;
        #1;
        check_eq("rstmid_s_req", bus.s_req, 0);
        check_eq("rstmid_gnt", {bus.m0_gnt, bus.m1_gnt}, 0);
        check_eq("rstmid_rddata", bus.m0_rddata, 0);
        check_eq("rstmid_s_addr", bus.s_addr, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        e.who = 0; e.err = 0; e.data = 32'h2468_ACE0;
        sb.push_back(e);
        @(negedge clk);
        check_eq("rstmid_no_done", done_cnt - dc, 0);
        check_eq("rstrel_gnt0", bus.m0_gnt, 1);
        check_eq("rstrel_gnt1", bus.m1_gnt, 0);
        @(posedge clk);
        #1;
        bus.m0_req = 0; bus.m1_req = 0;
        busy_phase(32'h500, 32'h0, 0, 1, 32'h2468_ACE0, 1, "rstrel");

        // Timeout disabled: stays BUSY without a done
        @(posedge clk);
        #1;
        bus_nt.m0_req = 1; bus_nt.m0_addr = 32'h600;
        @(negedge clk);
        check_eq("nt_gnt0", bus_nt.m0_gnt, 1);
        @(posedge clk);
        #1;
        bus_nt.m0_req = 0;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (bus_nt.s_req) n++;
        end
        check_eq("nt_busy_cycles", n, 1000);
        check_eq("nt_no_done", nt_done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, data bus width in bits.
REQ-002 Parameter ADDR_WIDTH, 32, address width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, 16, maximum BUSY cycles without s_ack before abort; 0 disables timeout.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 m0_req, m1_req  input  1 each  transaction request; m0 = core data port, m1 = DMA/debug port.
REQ-007 m0_wren, m1_wren  input  1 each  1 = write, 0 = read.
REQ-008 m0_addr, m1_addr  input  ADDR_WIDTH each  transaction address.
REQ-009 m0_wrdata, m1_wrdata  input  DATA_WIDTH each  write data.
REQ-010 m0_gnt, m1_gnt  output  1 each  one-cycle pulse when the request is accepted.
REQ-011 m0_done, m1_done  output  1 each  one-cycle pulse when the transaction ends.
REQ-012 m0_err, m1_err  output  1 each  qualifies done; 1 = timed out.
REQ-013 m0_rddata, m1_rddata  output  DATA_WIDTH each  read data; valid while done=1.
REQ-014 s_req, s_wren  output  1 each  shared-port request and direction.
REQ-015 s_addr, s_wrdata  output  ADDR_WIDTH, DATA_WIDTH  shared-port address and write data.
REQ-016 s_ack  input  1  slave completion; for reads, s_rddata is valid in the same cycle.
REQ-017 s_rddata  input  DATA_WIDTH  slave read data.

Function
REQ-018 The FSM SHALL have two states: IDLE and BUSY, plus an owner register (0/1) and a last-grant register (0/1).
REQ-019 In IDLE with any mX_req=1, the block SHALL combinationally pulse exactly one mX_gnt in that cycle, latch owner, wren, addr and wrdata, and enter BUSY on the next edge.
REQ-020 Arbitration is round-robin: if both requests are present, the requester that is not the last-grant winner wins; last-grant updates on every grant.
REQ-021 In BUSY, s_req SHALL be 1 with s_wren/s_addr/s_wrdata from the latched values, stable until exit; no mX_gnt in BUSY.
REQ-022 In IDLE, s_req SHALL be 0, and s_addr/s_wrdata/s_wren SHALL hold their last values.
REQ-023 s_ack=1 in BUSY ends the transaction: the next cycle has owner's done=1, err=0 and rddata=s_rddata captured at the ack (reads) or 0 (writes), with state IDLE.
REQ-024 BUSY cycle counter: cleared on BUSY entry, increments each BUSY cycle without ack; width SHALL be sized for TIMEOUT_CYCLES.
REQ-025 If TIMEOUT_CYCLES>0 and the TIMEOUT_CYCLES-th BUSY cycle passes without s_ack: exit to IDLE; the next cycle has done=1, err=1, rddata=0. s_req is therefore high for at most TIMEOUT_CYCLES cycles.
REQ-026 s_ack in the same cycle as the timeout limit SHALL count as a normal ack (err=0).
REQ-027 s_ack while IDLE SHALL be ignored and cause no done pulse.
REQ-028 done/err/rddata SHALL be registered; the non-owner's done/err are 0, and each rddata holds its value until the next done pulse for that requester.
REQ-029 A granted transaction completes even if its mX_req drops during BUSY; mX_req dropped before a grant receives no grant.
REQ-030 Throughput: minimum 3 cycles per transaction (grant/IDLE, BUSY with ack, done/IDLE); a new grant is allowed in the same IDLE cycle as a done pulse.
REQ-031 mX_req held after done SHALL be treated as a new request and arbitrated again.

Reset
REQ-032 rst=0 SHALL immediately force: state IDLE, last-grant=1 (m0 wins first tie), owner=0, counter=0, all gnt/done/err/s_req/s_wren=0, and all addr/data outputs=0.
REQ-033 Reset mid-transaction SHALL abort without a done pulse; after release, the first arbitration follows REQ-032 values.

Verification
REQ-034 m0 read of 0x100, s_ack on the 2nd BUSY cycle with s_rddata=0xCAFEF00D -> m0_gnt at cycle 0, s_req for 2 cycles, m0_done=1 and m0_rddata=0xCAFEF00D at cycle 3.
REQ-035 m0 and m1 both requesting continuously, s_ack in the first BUSY cycle -> grants alternate m0,m1,m0,m1 starting from m0, one grant per 2 cycles.
REQ-036 m1 write of 0x200 with 0x12345678 and s_ack never asserted, TIMEOUT_CYCLES=16 -> s_req high for exactly 16 cycles with constant addr/data, then m1_done=1, m1_err=1, m1_rddata=0.
REQ-037 s_ack on exactly the 16th BUSY cycle -> done with err=0; s_ack pulsed while IDLE -> no done.
REQ-038 rst asserted in the 2nd BUSY cycle -> s_req=0 asynchronously with no done; after release, simultaneous requests grant m0.
REQ-039 m0_req dropped in BUSY -> transaction still completes with m0_done; TIMEOUT_CYCLES=0 with no ack for 1000 cycles -> remains BUSY with no done.
